// File: rtl/rotary_pkg.sv
// Shared constants for the front-panel rotary encoder emulator.
// The decoder-side bench checks use ROT_ADDR_MAX as well.
package rotary_pkg;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PH1   = 3'd1;
   localparam logic [2:0] ST_PH2   = 3'd2;
   localparam logic [2:0] ST_PH3   = 3'd3;
   localparam logic [2:0] ST_PH4   = 3'd4;
   localparam logic [2:0] ST_PRESS = 3'd5;

   // Rotation direction: plus means B leads, minus means A leads
   localparam logic DIR_PLUS  = 1'b1;
   localparam logic DIR_MINUS = 1'b0;

   // Idle level of {Rot_A, Rot_B}
   localparam logic [1:0] ROT_IDLE_AB = 2'b11;

   // Upper clamp of the paired decoder's address counter
   localparam int ROT_ADDR_MAX = 1800;

   // Map the direction-neutral lead/lag line levels onto {A, B}
   function automatic logic [1:0] ab_lines(input logic dir, input logic lead, input logic lag);
      if (dir == DIR_PLUS)
         return {lag, lead};
      else
         return {lead, lag};
   endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// Loadable down-counter with a zero flag; times both detent phases and presses.
module rotary_phase_timer #(
   parameter int W = 4
) (
   input  logic         Fg_CLK,
   input  logic         RESET,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load on phase entry, otherwise count down and park at zero
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rotary_emulator.sv
// Drives the encoder lines Rot_A/Rot_B/Rot_C from a simple command interface.
// Lines idle high; each detent walks lead/lag through 01 -> 00 -> 10 -> 11.
module rotary_emulator
   import rotary_pkg::*;
#(
   parameter int PHASE_CYC = 8,
   parameter int PRESS_CYC = 1,
   parameter int STEP_W    = 12
) (
   input  logic              Fg_CLK,
   input  logic              RESET,
   input  logic              Cmd_Valid,
   output logic              Cmd_Ready,
   input  logic              Cmd_Press,
   input  logic              Cmd_Dir,
   input  logic [STEP_W-1:0] Cmd_Steps,
   output logic              Rot_A,
   output logic              Rot_B,
   output logic              Rot_C,
   output logic              Busy,
   output logic              Done
);

   localparam int TMR_MAX = (PHASE_CYC > PRESS_CYC) ? PHASE_CYC : PRESS_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   // The timer is loaded with N-1 so a phase lasts exactly N cycles
   localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(PHASE_CYC - 1);
   localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(PRESS_CYC - 1);

   logic [2:0]        state;
   logic              dir_q;
   logic [STEP_W-1:0] steps_q;
   logic [1:0]        rot_ab;
   logic              rot_c;
   logic              done_q;

   logic              accept;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_zero;
   logic              in_phase;

   assign accept   = Cmd_Valid & Cmd_Ready;
   assign in_phase = (state == ST_PH1) || (state == ST_PH2) ||
                     (state == ST_PH3) || (state == ST_PH4);

   // Reload the timer on every phase or press entry
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = PHASE_LOAD;
      if (state == ST_IDLE && accept) begin
         if (Cmd_Press) begin
            tmr_load = 1'b1;
            tmr_val  = PRESS_LOAD;
         end else if (Cmd_Steps != '0) begin
            tmr_load = 1'b1;
         end
      end else if (in_phase && tmr_zero) begin
         tmr_load = 1'b1;
      end
   end

   rotary_phase_timer #(
      .W (TMR_W)
   ) u_timer (
      .Fg_CLK   (Fg_CLK),
      .RESET    (RESET),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Command FSM; every output line is driven straight from a register here
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         state   <= ST_IDLE;
         dir_q   <= DIR_PLUS;
         steps_q <= '0;
         rot_ab  <= ROT_IDLE_AB;
         rot_c   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (Cmd_Press) begin
                     state <= ST_PRESS;
                     rot_c <= 1'b1;
                  end else if (Cmd_Steps != '0) begin
                     // Lead line drops on the accept edge itself
                     state   <= ST_PH1;
                     dir_q   <= Cmd_Dir;
                     steps_q <= Cmd_Steps;
                     rot_ab  <= ab_lines(Cmd_Dir, 1'b0, 1'b1);
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_PH1: begin
               if (tmr_zero) begin
                  state  <= ST_PH2;
                  rot_ab <= ab_lines(dir_q, 1'b0, 1'b0);
               end
            end
            ST_PH2: begin
               if (tmr_zero) begin
                  state  <= ST_PH3;
                  rot_ab <= ab_lines(dir_q, 1'b1, 1'b0);
               end
            end
            ST_PH3: begin
               if (tmr_zero) begin
                  state  <= ST_PH4;
                  rot_ab <= ab_lines(dir_q, 1'b1, 1'b1);
               end
            end
            ST_PH4: begin
               // End of the inter-detent gap: start the next detent or finish
               if (tmr_zero) begin
                  steps_q <= steps_q - 1'b1;
                  if (steps_q != STEP_W'(1)) begin
                     state  <= ST_PH1;
                     rot_ab <= ab_lines(dir_q, 1'b0, 1'b1);
                  end else begin
                     state  <= ST_IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_PRESS: begin
               if (tmr_zero) begin
                  state  <= ST_IDLE;
                  rot_c  <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               rot_ab <= ROT_IDLE_AB;
               rot_c  <= 1'b0;
            end
         endcase
      end
   end

   assign Rot_A     = rot_ab[1];
   assign Rot_B     = rot_ab[0];
   assign Rot_C     = rot_c;
   assign Done      = done_q;
   assign Cmd_Ready = (state == ST_IDLE);
   assign Busy      = ~Cmd_Ready;

endmodule
